// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the alarm ringer block.
//   state_t      : ringer controller states
//   BCD_TIME_W   : width of a BCD HH:MM time word
//   *_LSB        : bit offsets of the four BCD digits within a time word
package alarm_pkg;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
  localparam int BCD_TIME_W = 16;
  localparam int H_TENS_LSB = 12;
  localparam int H_UNITS_LSB = 8;
  localparam int M_TENS_LSB = 4;
  localparam int M_UNITS_LSB = 0;
endpackage

// File: rtl/alarm_tick_counter.sv
// alarm_tick_counter: counts tick pulses and flags the LIMIT-th one.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear, overrides tick
//   tick         : count enable pulse
//   expire       : combinational, high on the tick that completes LIMIT ticks
module alarm_tick_counter
  import alarm_pkg::*;
#(
  parameter int LIMIT = 60,
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic tick,
  output logic expire
);
  logic [W-1:0] cnt;
  assign expire = tick & (cnt == W'(LIMIT - 1));
  // Expiry returns the count to zero so it never wraps.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (clr | expire) ? '0 : cnt + W'(tick);
endmodule

// File: rtl/alarm_ringer_ctrl.sv
// alarm_ringer_ctrl: raises RINGER1 when the clock time reaches the alarm time, with snooze, stop and auto-off.
//   clk, reset_n : clock, asynchronous active-low reset
//   tick_1hz     : one-clk pulse per second
//   cur_time     : current BCD HH:MM
//   alarm_time   : programmed BCD HH:MM
//   alarm_en     : alarm armed level
//   snooze_btn   : one-clk snooze pulse
//   stop_btn     : one-clk stop pulse
//   RINGER1      : registered ring request
//   snoozing     : registered, high while snoozing
//   snooze_left  : registered count of snoozes still allowed
module alarm_ringer_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE = 3,
  localparam int SLW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick_1hz,
  input  logic [BCD_TIME_W-1:0] cur_time,
  input  logic [BCD_TIME_W-1:0] alarm_time,
  input  logic                  alarm_en,
  input  logic                  snooze_btn,
  input  logic                  stop_btn,
  output logic                  RINGER1,
  output logic                  snoozing,
  output logic [SLW-1:0]        snooze_left
);
  state_t state, nxt;
  logic match, match_d, trigger, go_snz, ring_exp, snz_exp;
  assign match = cur_time == alarm_time;
  // match_d resets high so a match already present at reset release is not an edge.
  assign trigger = match & ~match_d & alarm_en;
  assign go_snz = snooze_btn & (snooze_left != '0);
  // Each counter is held clear outside its own state, so every entry starts from zero.
  alarm_tick_counter #(.LIMIT(RING_SECS)) u_ring_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .clr(state != RINGING),
    .tick(tick_1hz & (state == RINGING)),
    .expire(ring_exp)
  );
  alarm_tick_counter #(.LIMIT(SNOOZE_SECS)) u_snz_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .clr(state != SNOOZE),
    .tick(tick_1hz & (state == SNOOZE)),
    .expire(snz_exp)
  );
  // Priority: disarm, stop, snooze, then tick expiry.
  always_comb
    nxt = (!alarm_en || stop_btn)           ? IDLE    :
          (state == IDLE && trigger)        ? RINGING :
          (state == RINGING && go_snz)      ? SNOOZE  :
          (state == RINGING && ring_exp)    ? IDLE    :
          (state == SNOOZE && snz_exp)      ? RINGING : state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      match_d <= 1'b1;
      RINGER1 <= 1'b0;
      snoozing <= 1'b0;
      snooze_left <= SLW'(MAX_SNOOZE);
    end else begin
      state <= nxt;
      match_d <= match;
      RINGER1 <= nxt == RINGING;
      snoozing <= nxt == SNOOZE;
      if (state == IDLE && nxt == RINGING) snooze_left <= SLW'(MAX_SNOOZE);
      else if (state == RINGING && nxt == SNOOZE) snooze_left <= snooze_left - SLW'(1);
    end
endmodule

// File: tb/tb_alarm_ringer_ctrl.sv
// tb_alarm_ringer_ctrl: scoreboard plus scenario tests for alarm_ringer_ctrl.
module tb_alarm_ringer_ctrl;
  localparam int RING = 4;
  localparam int SNZ = 3;
  localparam int MAXS = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick_1hz = 1'b0;
  logic [15:0] cur_time = 16'h0000;
  logic [15:0] alarm_time = 16'h0000;
  logic alarm_en = 1'b0;
  logic snooze_btn = 1'b0;
  logic stop_btn = 1'b0;
  logic RINGER1, snoozing;
  logic [1:0] snooze_left;
  logic [15:0] cur_v = 16'h0000;
  logic [15:0] alm_v = 16'h0000;
  logic en_v = 1'b0;
  int tcnt = 0;
  int checks = 0;
  int errors = 0;
  int m_mode = 0;
  int m_left = 0;
  logic [1:0] m_sl = 2'(MAXS);
  logic m_prev = 1'b1;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  alarm_ringer_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tick_1hz(tick_1hz),
    .cur_time(cur_time),
    .alarm_time(alarm_time),
    .alarm_en(alarm_en),
    .snooze_btn(snooze_btn),
    .stop_btn(stop_btn),
    .RINGER1(RINGER1),
    .snoozing(snoozing),
    .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({RINGER1, snoozing, snooze_left} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got ring=%b snz=%b left=%0d, want ring=%b snz=%b left=%0d",
                 $time, RINGER1, snoozing, snooze_left, e[3], e[2], e[1:0]);
      end
    end
  end

  // Applies one cycle of inputs at the falling edge and predicts the outputs after the next rising edge.
  task automatic drive(input logic snz, input logic stp);
    logic m;
    @(negedge clk);
    reset_n = 1'b1;
    cur_time = cur_v;
    alarm_time = alm_v;
    alarm_en = en_v;
    snooze_btn = snz;
    stop_btn = stp;
    tick_1hz = (tcnt == 9);
    tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    m = (cur_v == alm_v);
    if (!en_v || stp) m_mode = 0;
    else if (m_mode == 0) begin
      if (m && !m_prev) begin
        m_mode = 1;
        m_left = RING;
        m_sl = 2'(MAXS);
      end
    end else if (m_mode == 1) begin
      if (snz && m_sl != 0) begin
        m_mode = 2;
        m_left = SNZ;
        m_sl = m_sl - 2'd1;
      end else if (tick_1hz) begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end else if (tick_1hz) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 1;
        m_left = RING;
      end
    end
    m_prev = m;
    exp_q.push_back({m_mode == 1, m_mode == 2, m_sl});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic ring_up(input logic [15:0] pre, input logic [15:0] t);
    en_v = 1'b1;
    alm_v = t;
    cur_v = pre;
    idle_cycles(2);
    cur_v = t;
    idle_cycles(2);
  endtask

  task automatic wait_ring(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      drive(1'b0, 1'b0);
      if (RINGER1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: RINGER1 still 0 after 200 clks, want 1", name);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({RINGER1, snoozing, snooze_left} !== {1'b0, 1'b0, 2'(MAXS)}) begin
      errors++;
      $display("FAIL reset_values: got ring=%b snz=%b left=%0d, want 0 0 %0d", RINGER1, snoozing, snooze_left, MAXS);
    end
  endtask

  task automatic test_basic_ring;
    int n = 0;
    int high = 0;
    logic done = 1'b0;
    en_v = 1'b1;
    alm_v = 16'h0730;
    cur_v = 16'h0729;
    idle_cycles(3);
    cur_v = 16'h0730;
    drive(1'b0, 1'b0);
    checks++;
    if (RINGER1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_before_match: got %b want 0", RINGER1);
    end
    drive(1'b0, 1'b0);
    checks++;
    if (RINGER1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got %b want 1", RINGER1);
    end
    if (RINGER1 && tick_1hz) n++;
    for (int i = 0; i < 200 && !done; i++) begin
      drive(1'b0, 1'b0);
      if (RINGER1 && tick_1hz) n++;
      if (!RINGER1) done = 1'b1;
    end
    checks++;
    if (!done || n != RING) begin
      errors++;
      $display("FAIL basic_ring_ticks: got %0d ticks (ended=%b), want %0d", n, done, RING);
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0);
      if (RINGER1) high++;
    end
    checks++;
    if (high != 0) begin
      errors++;
      $display("FAIL basic_no_retrigger: got %0d ringing clks, want 0", high);
    end
    cur_v = 16'h0731;
    idle_cycles(2);
  endtask

  task automatic test_snooze;
    int n = 0;
    logic done = 1'b0;
    ring_up(16'h0759, 16'h0800);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if ({RINGER1, snoozing, snooze_left} !== 4'b0101) begin
      errors++;
      $display("FAIL snooze_first: got ring=%b snz=%b left=%0d, want 0 1 1", RINGER1, snoozing, snooze_left);
    end
    if (snoozing && tick_1hz) n++;
    for (int i = 0; i < 200 && !done; i++) begin
      drive(1'b0, 1'b0);
      if (snoozing && tick_1hz) n++;
      if (RINGER1) done = 1'b1;
    end
    checks++;
    if (!done || n != SNZ) begin
      errors++;
      $display("FAIL snooze_length: got %0d ticks (rerang=%b), want %0d", n, done, SNZ);
    end
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if ({snoozing, snooze_left} !== 3'b100) begin
      errors++;
      $display("FAIL snooze_second: got snz=%b left=%0d, want 1 0", snoozing, snooze_left);
    end
    wait_ring("snooze_rering2");
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if ({RINGER1, snoozing, snooze_left} !== 4'b1000) begin
      errors++;
      $display("FAIL snooze_third_ignored: got ring=%b snz=%b left=%0d, want 1 0 0", RINGER1, snoozing, snooze_left);
    end
    drive(1'b0, 1'b1);
    cur_v = 16'h0801;
    idle_cycles(2);
  endtask

  task automatic test_stop_disable;
    int high = 0;
    ring_up(16'h0859, 16'h0900);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    checks++;
    if ({RINGER1, snoozing} !== 2'b00) begin
      errors++;
      $display("FAIL stop_mid_ring: got ring=%b snz=%b, want 0 0", RINGER1, snoozing);
    end
    ring_up(16'h0900, 16'h0901);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    en_v = 1'b0;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if ({RINGER1, snoozing} !== 2'b00) begin
      errors++;
      $display("FAIL disable_in_snooze: got ring=%b snz=%b, want 0 0", RINGER1, snoozing);
    end
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b0);
      if (RINGER1) high++;
    end
    checks++;
    if (high != 0) begin
      errors++;
      $display("FAIL disable_no_rering: got %0d ringing clks, want 0", high);
    end
    cur_v = 16'h0902;
    en_v = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_priority;
    int n = 0;
    logic done = 1'b0;
    ring_up(16'h0959, 16'h1000);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    checks++;
    if ({RINGER1, snoozing} !== 2'b00) begin
      errors++;
      $display("FAIL prio_stop_over_snooze: got ring=%b snz=%b, want 0 0", RINGER1, snoozing);
    end
    ring_up(16'h1000, 16'h1001);
    if (RINGER1 && tick_1hz) n++;
    for (int i = 0; i < 200 && !done; i++) begin
      if (n == RING - 1 && tcnt == 9) begin
        drive(1'b1, 1'b0);
        done = 1'b1;
      end else begin
        drive(1'b0, 1'b0);
        if (RINGER1 && tick_1hz) n++;
      end
    end
    drive(1'b0, 1'b0);
    checks++;
    if (!done || {RINGER1, snoozing, snooze_left} !== 4'b0101) begin
      errors++;
      $display("FAIL prio_snooze_on_expiry: got ring=%b snz=%b left=%0d (reached=%b), want 0 1 1",
               RINGER1, snoozing, snooze_left, done);
    end
    drive(1'b0, 1'b1);
    cur_v = 16'h1002;
    idle_cycles(2);
  endtask

  task automatic test_back_to_back;
    int n = 0;
    logic done = 1'b0;
    ring_up(16'h1059, 16'h1100);
    if (RINGER1 && tick_1hz) n++;
    alm_v = 16'h1101;
    drive(1'b0, 1'b0);
    if (RINGER1 && tick_1hz) n++;
    cur_v = 16'h1101;
    for (int i = 0; i < 200 && !done; i++) begin
      drive(1'b0, 1'b0);
      if (RINGER1 && tick_1hz) n++;
      if (!RINGER1) done = 1'b1;
    end
    checks++;
    if (!done || n != RING) begin
      errors++;
      $display("FAIL retrigger_ignored: got %0d ring ticks (ended=%b), want %0d", n, done, RING);
    end
    cur_v = 16'h1102;
    idle_cycles(2);
  endtask

  task automatic test_reset_edge;
    int high = 0;
    ring_up(16'h1129, 16'h1130);
    drive(1'b1, 1'b0);
    wait_ring("reset_prep_rering");
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    m_mode = 0;
    m_sl = 2'(MAXS);
    m_prev = 1'b1;
    #1;
    checks++;
    if ({RINGER1, snoozing, snooze_left} !== {1'b0, 1'b0, 2'(MAXS)}) begin
      errors++;
      $display("FAIL async_reset_mid_ring: got ring=%b snz=%b left=%0d, want 0 0 %0d", RINGER1, snoozing, snooze_left, MAXS);
    end
    repeat (2) @(negedge clk);
    cur_time = 16'h1200;
    alarm_time = 16'h1200;
    alm_v = 16'h1200;
    cur_v = 16'h1200;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b0);
      if (RINGER1) high++;
    end
    checks++;
    if (high != 0) begin
      errors++;
      $display("FAIL reset_release_on_match: got %0d ringing clks, want 0", high);
    end
    cur_v = 16'h1201;
    idle_cycles(2);
  endtask

  task automatic test_disarmed_match;
    int high = 0;
    en_v = 1'b1;
    alm_v = 16'h1530;
    cur_v = 16'h1529;
    idle_cycles(2);
    en_v = 1'b0;
    cur_v = 16'h1530;
    idle_cycles(3);
    en_v = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b0);
      if (RINGER1) high++;
    end
    checks++;
    if (high != 0) begin
      errors++;
      $display("FAIL disarmed_match: got %0d ringing clks, want 0", high);
    end
  endtask

  initial begin
    test_reset;
    test_basic_ring;
    test_snooze;
    test_stop_disable;
    test_priority;
    test_back_to_back;
    test_reset_edge;
    test_disarmed_match;
    idle_cycles(2);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
